// File: rtl/spi_reg_bridge.sv
// SPI (mode 0) target that turns 24-bit host frames into single register-bus
// writes or reads. All SPI pins are oversampled on clk; SCK is never a clock.
module spi_reg_bridge #(
  parameter int                ADDR_W      = 7,
  parameter int                DATA_W      = 16,
  parameter int                TIMEOUT_CYC = 15,
  parameter logic [DATA_W-1:0] ERR_DATA    = 16'hDEAD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdat,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdat,
  input  logic              reg_ack,
  output logic              busy,
  output logic              err
);

  localparam int CMD_BITS   = 1 + ADDR_W;
  localparam int FRAME_BITS = CMD_BITS + DATA_W;
  localparam int BC_W       = $clog2(FRAME_BITS + 1);
  localparam int TC_W       = $clog2(TIMEOUT_CYC + 1);

  localparam logic [BC_W-1:0] LAST_CMD_BIT   = BC_W'(CMD_BITS - 1);
  localparam logic [BC_W-1:0] FIRST_SHIFT    = BC_W'(CMD_BITS);
  localparam logic [BC_W-1:0] LAST_FRAME_BIT = BC_W'(FRAME_BITS - 1);
  localparam logic [TC_W-1:0] LAST_WAIT      = TC_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WDATA,
    WR_REQ,
    RD_REQ,
    RDATA,
    DONE
  } state_t;

  state_t state;

  logic sck_meta, sck_sync, sck_prev;
  logic cs_meta, cs_sync, cs_prev;
  logic mosi_meta, mosi_sync;
  logic [1:0] sync_vld;
  logic armed;

  logic sck_rise, sck_fall, cs_fall, cs_rise, late_now;

  logic [BC_W-1:0]   bit_cnt;
  logic [BC_W-1:0]   fall_cnt;
  logic [TC_W-1:0]   wait_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] miso_sh;
  logic              miso_on;
  logic              data_late;
  logic              cs_left;

  // Two-flop synchronisers plus a history flop for edge detection; CS only
  // becomes "armed" once it has been seen high after reset, so a frame already
  // in progress at reset release is ignored until the next real CS fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_meta  <= 1'b0;
      sck_sync  <= 1'b0;
      sck_prev  <= 1'b0;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_prev   <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
      sync_vld  <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sck_meta  <= spi_sck;
      sck_sync  <= sck_meta;
      sck_prev  <= sck_sync;
      cs_meta   <= spi_cs_n;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      mosi_meta <= spi_mosi;
      mosi_sync <= mosi_meta;
      sync_vld  <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && cs_sync) armed <= 1'b1;
    end
  end

  assign sck_rise = sck_sync & ~sck_prev;
  assign sck_fall = ~sck_sync & sck_prev;
  assign cs_fall  = ~cs_sync & cs_prev;
  assign cs_rise  = cs_sync & ~cs_prev;
  assign late_now = sck_fall && (fall_cnt == LAST_CMD_BIT);

  assign spi_miso_oe = ~cs_sync;
  assign spi_miso    = miso_on & miso_sh[DATA_W-1];
  assign busy        = ((state != IDLE) && (state != DONE) && (bit_cnt != '0))
                       || reg_wr || reg_rd;

  // Frame sequencer: decodes the command byte, issues one bus request, and
  // streams read data back on MISO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      fall_cnt  <= '0;
      wait_cnt  <= '0;
      shift_reg <= '0;
      miso_sh   <= '0;
      miso_on   <= 1'b0;
      data_late <= 1'b0;
      cs_left   <= 1'b0;
      reg_addr  <= '0;
      reg_wdat  <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (sck_fall && (state != IDLE) && (state != DONE)) begin
        fall_cnt <= fall_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          cs_left   <= 1'b0;
          data_late <= 1'b0;
          miso_on   <= 1'b0;
          if (cs_fall && armed) begin
            bit_cnt  <= '0;
            fall_cnt <= '0;
            err      <= 1'b0;
            state    <= CMD;
          end
        end

        CMD: begin
          if (cs_rise) begin
            state <= IDLE;
          end else if (sck_rise) begin
            shift_reg <= {shift_reg[DATA_W-2:0], mosi_sync};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_CMD_BIT) begin
              reg_addr <= {shift_reg[ADDR_W-2:0], mosi_sync};
              wait_cnt <= '0;
              if (shift_reg[ADDR_W-1]) begin
                state <= WDATA;
              end else begin
                reg_rd <= 1'b1;
                state  <= RD_REQ;
              end
            end
          end
        end

        WDATA: begin
          if (cs_rise) begin
            state <= IDLE;
          end else if (sck_rise) begin
            shift_reg <= {shift_reg[DATA_W-2:0], mosi_sync};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_FRAME_BIT) begin
              reg_wdat <= {shift_reg[DATA_W-2:0], mosi_sync};
              reg_wr   <= 1'b1;
              wait_cnt <= '0;
              state    <= WR_REQ;
            end
          end
        end

        WR_REQ: begin
          if (cs_rise) cs_left <= 1'b1;
          if (reg_ack || (wait_cnt == LAST_WAIT)) begin
            reg_wr <= 1'b0;
            if (!reg_ack) err <= 1'b1;
            state <= (cs_left || cs_rise) ? IDLE : DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RD_REQ: begin
          if (cs_rise) cs_left <= 1'b1;
          if (late_now) begin
            data_late <= 1'b1;
            err       <= 1'b1;
          end
          if (reg_ack || (wait_cnt == LAST_WAIT)) begin
            reg_rd <= 1'b0;
            if (reg_ack) begin
              miso_sh <= reg_rdat;
            end else begin
              miso_sh <= ERR_DATA;
              err     <= 1'b1;
            end
            miso_on <= !(data_late || late_now || cs_left || cs_rise);
            state   <= (cs_left || cs_rise) ? IDLE : RDATA;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RDATA: begin
          if (cs_rise) begin
            miso_on <= 1'b0;
            state   <= IDLE;
          end else if (sck_fall) begin
            if (fall_cnt == LAST_FRAME_BIT) begin
              miso_on <= 1'b0;
              state   <= DONE;
            end else if (fall_cnt >= FIRST_SHIFT) begin
              miso_sh <= {miso_sh[DATA_W-2:0], 1'b0};
            end
          end
        end

        DONE: begin
          if (cs_rise) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: drives SPI frames at clk/8, models a
// register-bus responder, and scoreboards bus requests and MISO read data.
module tb_spi_reg_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [6:0]  reg_addr;
  logic [15:0] reg_wdat;
  logic        reg_wr;
  logic        reg_rd;
  logic [15:0] reg_rdat = 16'h0000;
  logic        reg_ack  = 1'b0;
  logic        busy;
  logic        err;

  typedef struct {
    logic [24:0] txn;
    int          len;
  } exp_t;

  exp_t        bus_q[$];
  logic [15:0] miso_q[$];
  int          compared   = 0;
  int          mismatched = 0;

  logic [15:0] mem [0:127] = '{3: 16'h00AB, default: 16'h0000};
  bit          ack_en  = 1'b1;
  int          ack_lat = 0;
  int          wait_n  = 0;
  int          req_len = 0;
  logic [15:0] rx;

  spi_reg_bridge dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .reg_addr    (reg_addr),
    .reg_wdat    (reg_wdat),
    .reg_wr      (reg_wr),
    .reg_rd      (reg_rd),
    .reg_rdat    (reg_rdat),
    .reg_ack     (reg_ack),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] all_outs();
    return {3'b000, reg_wr, reg_rd, reg_addr, reg_wdat, spi_miso, spi_miso_oe, busy, err};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI frame, mode 0, SCK = clk/8; 'gap' stretches the 8th SCK high phase
  task automatic applyStimulus(input logic [23:0] tx, input int nbits, input int gap,
                               input bit keep_cs, output logic [15:0] data);
    data = 16'h0000;
    spi_cs_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[23 - i];
      wait_clk(4);
      if (i >= 8) data = {data[14:0], spi_miso};
      spi_sck = 1'b1;
      wait_clk((i == 7) ? 4 + gap : 4);
      spi_sck = 1'b0;
    end
    wait_clk(4);
    if (!keep_cs) spi_cs_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    wait_clk(6);
    while ((busy || reg_wr || reg_rd) && (n < 80)) begin
      wait_clk(1);
      n++;
    end
    checkOutput(tag, 32'(n < 80), 32'd1);
  endtask

  // Responder: acks after ack_lat cycles of a visible request, backed by mem
  always @(posedge clk) begin
    #1;
    reg_ack = 1'b0;
    if (rst_n && (reg_wr || reg_rd)) begin
      if (ack_en && (wait_n == ack_lat)) begin
        reg_ack = 1'b1;
        if (reg_wr) mem[reg_addr] = reg_wdat;
        else reg_rdat = mem[reg_addr];
      end
      wait_n++;
    end else begin
      wait_n = 0;
    end
  end

  // Monitor: compares each bus request and its length against the scoreboard
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      if ((req_len != 0) && (bus_q.size() != 0)) void'(bus_q.pop_front());
      req_len = 0;
    end else if (reg_wr || reg_rd) begin
      if (req_len == 0) begin
        checkOutput("bus_expected", 32'(bus_q.size() != 0), 32'd1);
        if (bus_q.size() != 0) begin
          checkOutput("bus_txn",
                      32'({reg_wr, reg_rd, reg_addr, (reg_wr ? reg_wdat : 16'h0000)}),
                      32'(bus_q[0].txn));
        end
      end
      req_len++;
    end else if (req_len != 0) begin
      if (bus_q.size() != 0) begin
        checkOutput("bus_len", 32'(req_len), 32'(bus_q[0].len));
        void'(bus_q.pop_front());
      end
      req_len = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: run exceeded 1 ms, expected to finish well before");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    wait_clk(3);
    checkOutput("reset_held", all_outs(), 32'd0);
    rst_n = 1'b1;
    wait_clk(5);
    checkOutput("reset_state", all_outs(), 32'd0);

    $display("[TB] write 0x01 <= 0x1234");
    ack_lat = 2;
    bus_q.push_back('{txn: {2'b10, 7'h01, 16'h1234}, len: 3});
    applyStimulus(24'h811234, 24, 0, 1'b0, rx);
    wait_idle("write_idle");
    checkOutput("write_err", 32'(err), 32'd0);

    $display("[TB] read 0x03");
    ack_lat = 0;
    bus_q.push_back('{txn: {2'b01, 7'h03, 16'h0000}, len: 1});
    miso_q.push_back(16'h00AB);
    applyStimulus(24'h030000, 24, 0, 1'b0, rx);
    checkOutput("read_miso", 32'(rx), 32'(miso_q.pop_front()));
    wait_idle("read_idle");

    $display("[TB] read 0x10 with timeout, SCK stretched");
    ack_en = 1'b0;
    bus_q.push_back('{txn: {2'b01, 7'h10, 16'h0000}, len: 15});
    miso_q.push_back(16'hDEAD);
    applyStimulus(24'h100000, 24, 20, 1'b0, rx);
    checkOutput("timeout_miso", 32'(rx), 32'(miso_q.pop_front()));
    wait_idle("timeout_idle");
    checkOutput("timeout_err", 32'(err), 32'd1);

    $display("[TB] read 0x11 with timeout, data late at 8th fall");
    bus_q.push_back('{txn: {2'b01, 7'h11, 16'h0000}, len: 15});
    miso_q.push_back(16'h0000);
    applyStimulus(24'h110000, 24, 0, 1'b0, rx);
    checkOutput("late_miso", 32'(rx), 32'(miso_q.pop_front()));
    wait_idle("late_idle");
    checkOutput("late_err", 32'(err), 32'd1);

    $display("[TB] aborted write after 12 bits, then full write");
    ack_en  = 1'b1;
    ack_lat = 1;
    applyStimulus(24'h8A4321, 12, 0, 1'b0, rx);
    checkOutput("abort_err_cleared", 32'(err), 32'd0);
    wait_idle("abort_idle");
    bus_q.push_back('{txn: {2'b10, 7'h0A, 16'h4321}, len: 2});
    applyStimulus(24'h8A4321, 24, 0, 1'b0, rx);
    wait_idle("after_abort_idle");
    checkOutput("after_abort_err", 32'(err), 32'd0);

    $display("[TB] back-to-back write then read of 0x05");
    ack_lat = 0;
    bus_q.push_back('{txn: {2'b10, 7'h05, 16'hBEEF}, len: 1});
    bus_q.push_back('{txn: {2'b01, 7'h05, 16'h0000}, len: 1});
    miso_q.push_back(16'hBEEF);
    applyStimulus(24'h85BEEF, 24, 0, 1'b0, rx);
    wait_clk(4);
    applyStimulus(24'h050000, 24, 0, 1'b0, rx);
    checkOutput("b2b_miso", 32'(rx), 32'(miso_q.pop_front()));
    wait_idle("b2b_idle");

    $display("[TB] reset during an active write request");
    ack_en = 1'b0;
    bus_q.push_back('{txn: {2'b10, 7'h0C, 16'hA5A5}, len: 0});
    applyStimulus(24'h8CA5A5, 24, 0, 1'b1, rx);
    wait_clk(1);
    checkOutput("req_before_reset", 32'({reg_wr, busy}), 32'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_outputs", all_outs(), 32'd0);
    wait_clk(3);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      spi_mosi = i[0];
      wait_clk(4);
      spi_sck = 1'b1;
      wait_clk(4);
      spi_sck = 1'b0;
    end
    wait_clk(4);
    spi_cs_n = 1'b1;
    wait_clk(30);
    checkOutput("no_req_after_reset", 32'({reg_wr, reg_rd, busy}), 32'd0);

    $display("[TB] fresh write after reset");
    ack_en = 1'b1;
    bus_q.push_back('{txn: {2'b10, 7'h22, 16'h0F0F}, len: 1});
    applyStimulus(24'hA20F0F, 24, 0, 1'b0, rx);
    wait_idle("post_reset_idle");
    checkOutput("post_reset_err", 32'(err), 32'd0);

    checkOutput("scoreboard_empty", 32'(bus_q.size() + miso_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
